sync_updown_modulo_counter: RTL



---
 rtl/sync_updown_modulo_counter.sv | 80 ++++++++
 1 files changed

// File: rtl/sync_updown_modulo_counter.sv
// Parametrised up/down modulo counter: runtime modulus, load, enable, wrap/saturate.
// Optional sticky boundary flag (ovf_sticky/ovf_clr) when UDC_OVF_STICKY_EN is defined.
module sync_updown_modulo_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] max_val,
`ifdef UDC_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Limit comparisons happen before any +/-1, so the arithmetic never leaves WIDTH bits.
  always_comb begin
    // NOTE: defaults first so every path assigns q_next/wrap_next and no latch is inferred.
    q_next    = q;
    wrap_next = 1'b0;
    if (load_en) begin
      q_next = (data > max_val) ? max_val : data;
    end else if (en) begin
      if (up_down) begin
        if (q >= max_val) begin
          q_next    = SATURATE ? max_val : '0;
          wrap_next = 1'b1;
        end else begin
          q_next = q + 1'b1;
        end
      end else begin
        if (q > max_val) begin
          // Limit was lowered below the current count: pull back without flagging an event.
          q_next = max_val;
        end else if (q == '0) begin
          q_next    = SATURATE ? '0 : max_val;
          wrap_next = 1'b1;
        end else begin
          q_next = q - 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

`ifdef UDC_OVF_STICKY_EN
  // A boundary event on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)            ovf_sticky <= 1'b0;
    else if (wrap_next) ovf_sticky <= 1'b1;
    else if (ovf_clr)   ovf_sticky <= 1'b0;
  end
`endif

  assign tc = up_down ? (q >= max_val) : (q == '0);

endmodule
